// File: rtl/lru_stack_profiler_if.sv
// Trace request / completion bundle between the trace source and the LRU stack profiler.
interface lru_stack_profiler_if #(
    parameter int ADDR_W = 32,
    parameter int WAY_W  = 4
);
    logic              trace_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              busy;
    logic              done;
    logic              found;
    logic [WAY_W-1:0]  hit_pos;

    modport master (output trace_ready, mem_addr, input busy, done, found, hit_pos);
    modport slave  (input trace_ready, mem_addr, output busy, done, found, hit_pos);
endinterface

// File: rtl/lru_stack_profiler.sv
// Set-associative tag store kept in LRU-stack order; one pass yields hit counts
// for every power-of-two associativity up to WAY via stack distance.

module lru_way_cmp #(
    parameter int TAG_W = 22
) (
    input  logic             vld,
    input  logic [TAG_W-1:0] entry_tag,
    input  logic [TAG_W-1:0] ref_tag,
    output logic             match
);
    assign match = vld && (entry_tag == ref_tag);
endmodule

module lru_sat_cnt #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    // clear wins over increment; the counter sticks at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  cnt <= '0;
        else if (clr)                cnt <= '0;
        else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
    end
endmodule

module lru_stack_profiler #(
    parameter int ADDR_W      = 32,
    parameter int WAY         = 16,
    parameter int SET         = 64,
    parameter int BLOCK_BYTES = 16,
    parameter int CNT_W       = 20
) (
    input  logic                               clk,
    input  logic                               reset,
    lru_stack_profiler_if.slave                trc,
    input  logic                               clear_counts,
    output logic [($clog2(WAY)+1)*CNT_W-1:0]   hit_counts,
    output logic [CNT_W-1:0]                   access_count,
    output logic [CNT_W-1:0]                   miss_count,
    output logic [CNT_W-1:0]                   drop_count
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(SET);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = $clog2(WAY);
    localparam int NCFG  = WAY_W + 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;

    state_t           state_q, state_d;
    logic [TAG_W-1:0] tag_q [SET][WAY];
    logic [WAY-1:0]   vld_q [SET];
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [WAY-1:0]   match;
    logic             hit;
    logic [WAY_W-1:0] hit_idx;
    logic [WAY_W-1:0] upd_pos;
    logic             found_q, done_q;
    logic [WAY_W-1:0] pos_q;
    logic             accept, drop, lookup, update;
    logic [NCFG-1:0]  hit_inc;
    logic             unused_off;

    assign accept     = (state_q == IDLE) && trc.trace_ready;
    assign drop       = (state_q != IDLE) && trc.trace_ready;
    assign lookup     = (state_q == LOOKUP);
    assign update     = (state_q == UPDATE);
    assign unused_off = ^trc.mem_addr[OFF_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trc.trace_ready) state_d = LOOKUP;
            LOOKUP:  state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // one comparator per way, all against the registered request tag
    for (genvar w = 0; w < WAY; w++) begin : g_way
        lru_way_cmp #(.TAG_W(TAG_W)) u_cmp (
            .vld       (vld_q[req_idx][w]),
            .entry_tag (tag_q[req_idx][w]),
            .ref_tag   (req_tag),
            .match     (match[w])
        );
    end

    assign hit = |match;

    // lowest matching position is the stack distance
    always_comb begin
        hit_idx = '0;
        for (int w = WAY - 1; w >= 0; w--)
            if (match[w]) hit_idx = WAY_W'(w);
    end

    // a miss shifts the whole stack, dropping the old LRU entry
    assign upd_pos = found_q ? pos_q : WAY_W'(WAY - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_tag <= '0;
            req_idx <= '0;
            found_q <= 1'b0;
            pos_q   <= '0;
            done_q  <= 1'b0;
            for (int s = 0; s < SET; s++) vld_q[s] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= update;
            if (accept) begin
                req_tag <= trc.mem_addr[ADDR_W-1 -: TAG_W];
                req_idx <= trc.mem_addr[OFF_W +: IDX_W];
            end
            if (lookup) begin
                found_q <= hit;
                pos_q   <= hit ? hit_idx : '0;
            end
            if (update) begin
                for (int i = 1; i < WAY; i++)
                    if (WAY_W'(i) <= upd_pos) vld_q[req_idx][i] <= vld_q[req_idx][i-1];
                vld_q[req_idx][0] <= 1'b1;
            end
        end
    end

    // tags need no reset: they are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (update) begin
            for (int i = 1; i < WAY; i++)
                if (WAY_W'(i) <= upd_pos) tag_q[req_idx][i] <= tag_q[req_idx][i-1];
            tag_q[req_idx][0] <= req_tag;
        end
    end

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        assign hit_inc[k] = lookup && hit && (int'(hit_idx) < (1 << k));
        lru_sat_cnt #(.CNT_W(CNT_W)) u_hit (
            .clk(clk), .reset(reset), .clr(clear_counts), .inc(hit_inc[k]),
            .cnt(hit_counts[k*CNT_W +: CNT_W])
        );
    end

    lru_sat_cnt #(.CNT_W(CNT_W)) u_acc (
        .clk(clk), .reset(reset), .clr(clear_counts), .inc(accept), .cnt(access_count)
    );
    lru_sat_cnt #(.CNT_W(CNT_W)) u_miss (
        .clk(clk), .reset(reset), .clr(clear_counts), .inc(lookup && !hit), .cnt(miss_count)
    );
    lru_sat_cnt #(.CNT_W(CNT_W)) u_drop (
        .clk(clk), .reset(reset), .clr(clear_counts), .inc(drop), .cnt(drop_count)
    );

    assign trc.busy    = (state_q != IDLE);
    assign trc.done    = done_q;
    assign trc.found   = found_q;
    assign trc.hit_pos = pos_q;
endmodule

// File: tb/tb_lru_stack_profiler.sv
// Bench for lru_stack_profiler: directed and random traces against a queue-based LRU model.
module tb_lru_stack_profiler;
    localparam int ADDR_W = 32, WAY = 16, SET = 64, WAY_W = 4, NCFG = 5, TAG_W = 22;
    localparam int CW_A = 20, CW_B = 4;
    localparam longint MAXA = (64'd1 << CW_A) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, b_rst, a_clr, b_clr;
    logic [NCFG*CW_A-1:0] a_hits;
    logic [CW_A-1:0]      a_acc, a_miss, a_drop;
    logic [NCFG*CW_B-1:0] b_hits;
    logic [CW_B-1:0]      b_acc, b_miss, b_drop;

    lru_stack_profiler_if #(.ADDR_W(ADDR_W), .WAY_W(WAY_W)) a_if ();
    lru_stack_profiler_if #(.ADDR_W(ADDR_W), .WAY_W(WAY_W)) b_if ();

    lru_stack_profiler #(.CNT_W(CW_A)) dut_a (
        .clk(clk), .reset(a_rst), .trc(a_if), .clear_counts(a_clr), .hit_counts(a_hits),
        .access_count(a_acc), .miss_count(a_miss), .drop_count(a_drop)
    );
    lru_stack_profiler #(.CNT_W(CW_B)) dut_b (
        .clk(clk), .reset(b_rst), .trc(b_if), .clear_counts(b_clr), .hit_counts(b_hits),
        .access_count(b_acc), .miss_count(b_miss), .drop_count(b_drop)
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
        end
    endtask

    // reference: one most-recent-first queue of tags per set
    logic [TAG_W-1:0] stk [SET][$];
    longint m_acc, m_miss, m_drop;
    longint m_hit [NCFG];
    bit     m_found;
    int     m_pos;

    function automatic longint sat(input longint v);
        return (v >= MAXA) ? MAXA : v + 1;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < SET; s++) stk[s].delete();
        m_acc = 0; m_miss = 0; m_drop = 0; m_found = 0; m_pos = 0;
        for (int k = 0; k < NCFG; k++) m_hit[k] = 0;
    endtask

    task automatic m_access(input logic [31:0] a);
        int s;
        logic [TAG_W-1:0] t;
        int d;
        s = int'(a[9:4]);
        t = a[31:10];
        d = -1;
        m_acc = sat(m_acc);
        for (int i = 0; i < stk[s].size(); i++)
            if (d < 0 && stk[s][i] == t) d = i;
        if (d < 0) begin
            m_miss = sat(m_miss); m_found = 0; m_pos = 0;
            stk[s].push_front(t);
            if (stk[s].size() > WAY) void'(stk[s].pop_back());
        end else begin
            m_found = 1; m_pos = d;
            for (int k = 0; k < NCFG; k++)
                if (d < (1 << k)) m_hit[k] = sat(m_hit[k]);
            stk[s].delete(d);
            stk[s].push_front(t);
        end
    endtask

    task automatic chk_a(input string tg);
        chk({tg, ".found"}, a_if.found, m_found);
        chk({tg, ".pos"}, a_if.hit_pos, m_pos);
        for (int k = 0; k < NCFG; k++)
            chk($sformatf("%s.hit%0d", tg, 1 << k), a_hits[k*CW_A +: CW_A], m_hit[k]);
        chk({tg, ".acc"}, a_acc, m_acc);
        chk({tg, ".miss"}, a_miss, m_miss);
        chk({tg, ".drop"}, a_drop, m_drop);
    endtask

    task automatic a_reset();
        @(negedge clk);
        a_rst = 1'b0; a_if.trace_ready = 1'b0; a_clr = 1'b0;
        m_reset();
        @(negedge clk); @(negedge clk);
        a_rst = 1'b1;
    endtask

    task automatic a_access(input logic [31:0] addr, input string tg);
        @(negedge clk);
        a_if.trace_ready = 1'b1; a_if.mem_addr = addr;
        @(negedge clk);
        a_if.trace_ready = 1'b0;
        chk({tg, ".busy0"}, a_if.busy, 1);
        @(negedge clk);
        chk({tg, ".busy1"}, a_if.busy, 1);
        chk({tg, ".done1"}, a_if.done, 0);
        @(negedge clk);
        chk({tg, ".busy2"}, a_if.busy, 0);
        chk({tg, ".done2"}, a_if.done, 1);
        m_access(addr);
        chk_a(tg);
    endtask

    task automatic b_access(input logic [31:0] addr, input string tg, input bit ef, input int ep);
        @(negedge clk);
        b_if.trace_ready = 1'b1; b_if.mem_addr = addr;
        @(negedge clk);
        b_if.trace_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk({tg, ".done"}, b_if.done, 1);
        chk({tg, ".found"}, b_if.found, ef);
        chk({tg, ".pos"}, b_if.hit_pos, ep);
    endtask

    task automatic chk_b(input string tg, input int acc, input int miss, input int hit);
        chk({tg, ".acc"}, b_acc, acc);
        chk({tg, ".miss"}, b_miss, miss);
        chk({tg, ".drop"}, b_drop, 0);
        for (int k = 0; k < NCFG; k++)
            chk($sformatf("%s.hit%0d", tg, 1 << k), b_hits[k*CW_B +: CW_B], hit);
    endtask

    logic [31:0] burst [9];
    logic [31:0] ra;

    initial begin
        a_rst = 1'b0; b_rst = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
        a_if.trace_ready = 1'b0; a_if.mem_addr = '0;
        b_if.trace_ready = 1'b0; b_if.mem_addr = '0;
        m_reset();
        repeat (3) @(negedge clk);
        a_rst = 1'b1; b_rst = 1'b1;

        // reset state
        chk("rst.busy", a_if.busy, 0);
        chk("rst.done", a_if.done, 0);
        chk_a("rst");

        // cold miss, then immediate re-hit at the MRU position
        a_access(32'h0000_0000, "t1");
        chk("t1.miss_is_1", a_miss, 1);
        a_access(32'h0000_0000, "t2");
        chk("t2.hit16_is_1", a_hits[4*CW_A +: CW_A], 1);

        // depth-2 hit within set 0
        a_access(32'h0000_0000, "t3a");
        a_access(32'h0000_0400, "t3b");
        a_access(32'h0000_0800, "t3c");
        a_access(32'h0000_0000, "t3d");
        chk("t3.pos_is_2", a_if.hit_pos, 2);

        // overflow one set past WAY entries
        a_reset();
        for (int n = 0; n <= 16; n++)
            a_access(32'h050 + n * 32'h400, $sformatf("t4.n%0d", n));
        a_access(32'h050, "t4.again0");
        chk("t4.miss_is_18", a_miss, 18);
        a_access(32'h050 + 16 * 32'h400, "t4.again16");
        chk("t4.pos_is_1", a_if.hit_pos, 1);

        // held trace_ready: only IDLE cycles accept, the rest drop
        burst[0] = 32'h1234_5670; burst[3] = 32'h4321_0670; burst[6] = 32'h1234_5678;
        for (int c = 0; c < 9; c++)
            if (c % 3 != 0) burst[c] = $urandom;
        for (int c = 0; c < 9; c++) begin
            a_if.trace_ready = 1'b1; a_if.mem_addr = burst[c];
            if (c % 3 == 0) m_access(burst[c]);
            else            m_drop = sat(m_drop);
            @(negedge clk);
        end
        a_if.trace_ready = 1'b0;
        chk("t5.done", a_if.done, 1);
        chk("t5.drop_is_6", a_drop, 6);
        chk_a("t5");

        // random traffic over a few sets and more tags than ways
        for (int i = 0; i < 60; i++) begin
            ra = ({10'd0, 22'($urandom_range(0, 19))} << 10)
               | ({26'd0, 6'($urandom_range(0, 3))} << 4)
               | {28'd0, 4'($urandom_range(0, 15))};
            a_access(ra, $sformatf("rnd%0d", i));
        end

        // narrow counters: saturation, clear, reset mid-flight
        for (int n = 0; n <= 16; n++)
            b_access(32'(n) << 4, $sformatf("t6.m%0d", n), 0, 0);
        chk_b("t6.sat", 15, 15, 0);
        @(negedge clk); b_clr = 1'b1;
        @(negedge clk); b_clr = 1'b0;
        chk_b("t6.clr", 0, 0, 0);
        b_access(32'h0, "t6.keep", 1, 0);
        chk_b("t6.keep", 1, 0, 1);
        @(negedge clk);
        b_if.trace_ready = 1'b1; b_if.mem_addr = 32'h10;
        @(negedge clk);
        b_if.trace_ready = 1'b0;
        chk("t6.inflight", b_if.busy, 1);
        b_rst = 1'b0;
        #1;
        chk("t6.rst.busy", b_if.busy, 0);
        chk("t6.rst.found", b_if.found, 0);
        chk_b("t6.rst", 0, 0, 0);
        @(negedge clk); @(negedge clk);
        b_rst = 1'b1;
        b_access(32'h10, "t6.post", 0, 0);
        chk_b("t6.post", 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
